arc4_crack_dispatcher: RTL and testbench
========================================

Name: arc4_crack_dispatcher

Overview:
- Parametrised key-space dispatcher for NUM_CORES ARC4 crack cores; generalises the fixed two-core split cracker to N cores with dynamic chunk allocation.
- Sits between the top-level FPGA wrapper and the crack core array.
- Hands fixed-size key chunks to idle cores and collects results.
- On the first hit it aborts all other cores, drains them and reports the key; if the whole key space is searched without a hit, it reports "not found".

Parameters:
NUM_CORES, 2, number of crack cores attached (1..16)
KEY_W, 24, key width in bits; key space is 0 .. 2^KEY_W-1
CHUNK_LOG2, 12, log2 of keys per chunk; must satisfy CHUNK_LOG2 <= KEY_W

Ports:
clk  in  1  single system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  start request; accepted only in a cycle where rdy=1
rdy  out  1  1 when idle and able to accept en
done  out  1  1 from search completion until next accepted en
key_valid  out  1  1 with done when a key was found
key  out  KEY_W  found key; valid when key_valid=1
chunks_done  out  KEY_W-CHUNK_LOG2+1  count of chunks completed without a hit
core_en  out  NUM_CORES  one-cycle start pulse per core
core_base  out  NUM_CORES*KEY_W  chunk base key per core; held stable while that core runs
core_abort  out  NUM_CORES  one-cycle abort pulse per core
core_rdy  in  NUM_CORES  core idle
core_done  in  NUM_CORES  one-cycle pulse; core finished its chunk or abort
core_found  in  NUM_CORES  qualifies core_done: hit in chunk
core_key  in  NUM_CORES*KEY_W  core's hit key; valid with core_done & core_found

Behaviour:
- Reset (async, any state): state=IDLE, rdy=1, done=0, key_valid=0, key=0, chunks_done=0, core_en=0, core_abort=0, core_base=0, next_base=0, busy mask=0.
- next_base is KEY_W+1 bits. Increments by 2^CHUNK_LOG2 per dispatch. MSB set means the key space is exhausted; no wrap to 0.
- IDLE:
  - rdy=1.
  - en=1 → clear done, key_valid, chunks_done, next_base and busy mask; go to RUN. rdy drops the next cycle.
- RUN: each cycle, in this order:
  - (a) Collect:
    - For every core with core_done=1: clear its busy bit.
    - If core_found=0: chunks_done += 1 (multiple same-cycle completions all counted).
    - If any core_found=1: latch core_key of the lowest-index hitting core into key, set key_valid, go to ABORT. No dispatch this cycle.
  - (b) Dispatch, only if no hit:
    - Lowest-index core with core_rdy=1, busy=0 and next_base MSB=0 gets core_base=next_base[KEY_W-1:0], a core_en pulse and its busy bit set; next_base advances.
    - At most one dispatch per cycle.
    - A core whose done pulse arrives this cycle is eligible only from the next cycle.
  - (c) Exhaustion: next_base MSB=1 and busy mask=0 → DONE with key_valid=0.
- ABORT:
  - One cycle.
  - core_abort pulsed for every core whose busy bit is set. Aborted cores answer with core_done; core_found is ignored from here on.
  - Go to DRAIN.
- DRAIN:
  - Clear busy bits on core_done.
  - When busy mask=0 and core_rdy is all ones → DONE.
  - key, key_valid and chunks_done are frozen.
- DONE:
  - done=1, rdy=1; outputs hold.
  - en=1 → restart as from IDLE (same cycle clears done).
- en while rdy=0 is ignored.
- Core protocol violations are not handled: core_done without busy, or core_found during DRAIN.
- Latency:
  - First core_en is 1 cycle after en is accepted.
  - done rises 1 cycle after the final core_done.
  - For a hit with no other busy cores, done follows ABORT → DRAIN → DONE: 3 cycles after the hit.
- CHUNK_LOG2=KEY_W: single chunk, only core 0 is used.

Test Plan:
- NUM_CORES=4, KEY_W=8, CHUNK_LOG2=4, behavioural cores with fixed latency 20 and no hit; pulse en → core_en to cores 0,1,2,3 on four consecutive cycles with bases 0x00,0x10,0x20,0x30; 16 chunks total; done=1, key_valid=0, chunks_done=16; no base dispatched twice.
- Same config, core model hits on key 0x5A → key=0x5A, key_valid=1; core_abort pulsed only to the other busy cores; done only after all core_rdy=1; chunks_done < 16.
- Cores 1 and 3 assert core_done&core_found in the same cycle with keys 0x1F and 0x3F → key=0x1F.
- Unequal core latencies (core0=5, core1=40) → core0 receives more chunks; dispatch is always to the lowest idle index; exhaustion is detected only when core1 drains.
- Assert rst_n=0 mid-RUN with two cores busy → all outputs return to reset values immediately (asynchronously); subsequent en gives a clean search from base 0.
- en held high during RUN → ignored; en in DONE → restarts, done falls the next cycle, chunks_done is cleared.

Source files
------------

// File: rtl/arc4_crack_dispatcher.sv
// rtl/arc4_crack_dispatcher.sv - key-space chunk dispatcher for an array of ARC4 crack cores
//
// Splits the key space 0 .. 2^KEY_W-1 into chunks of 2^CHUNK_LOG2 keys and hands
// them to idle cores. The first hit aborts every other busy core, waits for them
// to drain and reports the key. If every chunk misses, it reports "not found".
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   en / rdy            start request, accepted only while rdy=1
//   done                search finished; held until the next accepted en
//   key_valid, key      hit flag and hit key (valid with done)
//   chunks_done         number of chunks searched without a hit
//   core_en             one-cycle start pulse per core
//   core_base           chunk base key per core (KEY_W bits per core)
//   core_abort          one-cycle abort pulse per core
//   core_rdy            core idle
//   core_done           core finished its chunk or its abort
//   core_found          qualifies core_done: key found in chunk
//   core_key            core hit key (KEY_W bits per core)
module arc4_crack_dispatcher #(
    parameter int NUM_CORES  = 2,
    parameter int KEY_W      = 24,
    parameter int CHUNK_LOG2 = 12
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    output logic                          rdy,
    output logic                          done,
    output logic                          key_valid,
    output logic [KEY_W-1:0]              key,
    output logic [KEY_W-CHUNK_LOG2:0]     chunks_done,
    output logic [NUM_CORES-1:0]          core_en,
    output logic [NUM_CORES*KEY_W-1:0]    core_base,
    output logic [NUM_CORES-1:0]          core_abort,
    input  logic [NUM_CORES-1:0]          core_rdy,
    input  logic [NUM_CORES-1:0]          core_done,
    input  logic [NUM_CORES-1:0]          core_found,
    input  logic [NUM_CORES*KEY_W-1:0]    core_key
);

    localparam int CNT_W = KEY_W - CHUNK_LOG2 + 1;
    localparam logic [KEY_W:0] CHUNK_INC = {{KEY_W{1'b0}}, 1'b1} << CHUNK_LOG2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_ABORT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                     state_q, state_d;
    logic                       rdy_q, rdy_d;
    logic                       done_q, done_d;
    logic                       key_valid_q, key_valid_d;
    logic [KEY_W-1:0]           key_q, key_d;
    logic [CNT_W-1:0]           chunks_done_q, chunks_done_d;
    logic [NUM_CORES-1:0]       core_en_q, core_en_d;
    logic [NUM_CORES-1:0]       core_abort_q, core_abort_d;
    logic [NUM_CORES*KEY_W-1:0] core_base_q, core_base_d;
    logic [NUM_CORES-1:0]       busy_q, busy_d;
    // MSB set means every chunk has been handed out; the counter never wraps.
    logic [KEY_W:0]             next_base_q, next_base_d;

    logic                       hit;
    logic [KEY_W-1:0]           hit_key;
    logic [CNT_W-1:0]           miss_cnt;
    logic                       disp_ok;
    logic                       disp_taken;

    always_comb begin
        state_d       = state_q;
        rdy_d         = rdy_q;
        done_d        = done_q;
        key_valid_d   = key_valid_q;
        key_d         = key_q;
        chunks_done_d = chunks_done_q;
        core_en_d     = '0;
        core_abort_d  = '0;
        core_base_d   = core_base_q;
        busy_d        = busy_q;
        next_base_d   = next_base_q;
        hit           = 1'b0;
        hit_key       = '0;
        miss_cnt      = '0;
        disp_ok       = 1'b0;
        disp_taken    = 1'b0;

        // Several cores may complete in the same cycle; every miss counts.
        for (int i = 0; i < NUM_CORES; i++) begin
            if (core_done[i] && !core_found[i]) begin
                miss_cnt = miss_cnt + CNT_W'(1);
            end
        end

        // Scan high to low so the lowest-index hitting core wins.
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (core_done[i] && core_found[i]) begin
                hit     = 1'b1;
                hit_key = core_key[i*KEY_W +: KEY_W];
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (en) begin
                    // Accept and issue the first chunk in the same cycle.
                    state_d       = S_RUN;
                    rdy_d         = 1'b0;
                    done_d        = 1'b0;
                    key_valid_d   = 1'b0;
                    chunks_done_d = '0;
                    next_base_d   = '0;
                    busy_d        = '0;
                    disp_ok       = 1'b1;
                end
            end
            S_RUN: begin
                busy_d        = busy_q & ~core_done;
                chunks_done_d = chunks_done_q + miss_cnt;
                if (hit) begin
                    key_d        = hit_key;
                    key_valid_d  = 1'b1;
                    state_d      = S_ABORT;
                    // Pulse lands in the ABORT cycle, aimed at cores still working.
                    core_abort_d = busy_d;
                end else begin
                    disp_ok = 1'b1;
                end
            end
            S_ABORT: begin
                busy_d  = busy_q & ~core_done;
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                busy_d = busy_q & ~core_done;
                if (busy_d == '0 && (&core_rdy)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    rdy_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                rdy_d   = 1'b1;
            end
        endcase

        // A core whose done pulse arrives now is only eligible next cycle.
        if (disp_ok && !next_base_d[KEY_W]) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (!disp_taken && core_rdy[i] && !core_done[i] && !busy_d[i]) begin
                    disp_taken                     = 1'b1;
                    core_en_d[i]                   = 1'b1;
                    busy_d[i]                      = 1'b1;
                    core_base_d[i*KEY_W +: KEY_W]  = next_base_d[KEY_W-1:0];
                end
            end
            if (disp_taken) begin
                next_base_d = next_base_d + CHUNK_INC;
            end
        end

        if (state_q == S_RUN && !hit && next_base_d[KEY_W] && busy_d == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            rdy_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            rdy_q         <= 1'b1;
            done_q        <= 1'b0;
            key_valid_q   <= 1'b0;
            key_q         <= '0;
            chunks_done_q <= '0;
            core_en_q     <= '0;
            core_abort_q  <= '0;
            core_base_q   <= '0;
            busy_q        <= '0;
            next_base_q   <= '0;
        end else begin
            state_q       <= state_d;
            rdy_q         <= rdy_d;
            done_q        <= done_d;
            key_valid_q   <= key_valid_d;
            key_q         <= key_d;
            chunks_done_q <= chunks_done_d;
            core_en_q     <= core_en_d;
            core_abort_q  <= core_abort_d;
            core_base_q   <= core_base_d;
            busy_q        <= busy_d;
            next_base_q   <= next_base_d;
        end
    end

    assign rdy         = rdy_q;
    assign done        = done_q;
    assign key_valid   = key_valid_q;
    assign key         = key_q;
    assign chunks_done = chunks_done_q;
    assign core_en     = core_en_q;
    assign core_abort  = core_abort_q;
    assign core_base   = core_base_q;

endmodule

// File: tb/tb_arc4_crack_dispatcher.sv
// tb/tb_arc4_crack_dispatcher.sv - directed self-checking bench for arc4_crack_dispatcher
module tb_arc4_crack_dispatcher;

    localparam int NC     = 4;
    localparam int KW     = 8;
    localparam int CL     = 4;
    localparam int NCHUNK = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic              rdy;
    logic              done;
    logic              key_valid;
    logic [KW-1:0]     key;
    logic [KW-CL:0]    chunks_done;
    logic [NC-1:0]     core_en;
    logic [NC*KW-1:0]  core_base;
    logic [NC-1:0]     core_abort;
    logic [NC-1:0]     core_rdy;
    logic [NC-1:0]     core_done;
    logic [NC-1:0]     core_found;
    logic [NC*KW-1:0]  core_key;

    arc4_crack_dispatcher #(
        .NUM_CORES  (NC),
        .KEY_W      (KW),
        .CHUNK_LOG2 (CL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .rdy         (rdy),
        .done        (done),
        .key_valid   (key_valid),
        .key         (key),
        .chunks_done (chunks_done),
        .core_en     (core_en),
        .core_base   (core_base),
        .core_abort  (core_abort),
        .core_rdy    (core_rdy),
        .core_done   (core_done),
        .core_found  (core_found),
        .core_key    (core_key)
    );

    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    // Core model configuration (written by the stimulus only)
    int lat [NC];
    bit present [NC];
    int hk0;
    int hk1;

    // Core model state and logs (written by the model only)
    int            cnt [NC];
    bit            run [NC];
    bit            aborted [NC];
    int            mbase [NC];
    int            n_disp;
    int            disp_core [64];
    int            disp_base [64];
    int            disp_cyc [64];
    int            per_core [NC];
    int            last_done [NC];
    int            base_cnt [NCHUNK];
    logic [NC-1:0] abort_seen;
    int            abort_cycles;

    int n_checks;
    int n_pass;

    function automatic int hit_in(input int b);
        if (hk0 >= b && hk0 < b + 16) return hk0;
        if (hk1 >= b && hk1 < b + 16) return hk1;
        return -1;
    endfunction

    // Behavioural cores: fixed latency per core, answer an abort one cycle later.
    always @(negedge clk) begin
        if (!rst_n) begin
            n_disp       = 0;
            abort_seen   = '0;
            abort_cycles = 0;
            core_done    = '0;
            core_found   = '0;
            core_key     = '0;
            for (int i = 0; i < NC; i++) begin
                run[i]       = 1'b0;
                aborted[i]   = 1'b0;
                cnt[i]       = 0;
                per_core[i]  = 0;
                last_done[i] = 0;
                core_rdy[i]  = present[i];
            end
            for (int c = 0; c < NCHUNK; c++) base_cnt[c] = 0;
        end else begin
            abort_seen = abort_seen | core_abort;
            if (core_abort != '0) abort_cycles++;
            for (int i = 0; i < NC; i++) begin
                core_done[i]  = 1'b0;
                core_found[i] = 1'b0;
                if (run[i]) begin
                    if (core_abort[i]) begin
                        aborted[i] = 1'b1;
                        cnt[i]     = 1;
                    end else begin
                        cnt[i]--;
                        if (cnt[i] == 0) begin
                            run[i]       = 1'b0;
                            core_done[i] = 1'b1;
                            core_rdy[i]  = 1'b1;
                            last_done[i] = cyc;
                            if (!aborted[i] && hit_in(mbase[i]) >= 0) begin
                                core_found[i]           = 1'b1;
                                core_key[i*KW +: KW]    = KW'(hit_in(mbase[i]));
                            end
                        end
                    end
                end else if (core_en[i]) begin
                    run[i]      = 1'b1;
                    aborted[i]  = 1'b0;
                    cnt[i]      = lat[i];
                    core_rdy[i] = 1'b0;
                    mbase[i]    = int'(core_base[i*KW +: KW]);
                    per_core[i]++;
                    base_cnt[mbase[i] >> CL]++;
                    if (n_disp < 64) begin
                        disp_core[n_disp] = i;
                        disp_base[n_disp] = mbase[i];
                        disp_cyc[n_disp]  = cyc;
                        n_disp++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic do_reset(input int l0, input int l1, input int l2, input int l3,
                            input logic [NC-1:0] pres, input int k0, input int k1);
        lat[0] = l0;
        lat[1] = l1;
        lat[2] = l2;
        lat[3] = l3;
        for (int i = 0; i < NC; i++) present[i] = pres[i];
        hk0   = k0;
        hk1   = k1;
        en    = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic start(output int a);
        en = 1'b1;
        a  = cyc;
        tick();
        en = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit, output int t);
        int k;
        k = 0;
        while (done !== 1'b1 && k < limit) begin
            tick();
            k++;
        end
        t = cyc;
        chk(tag, {31'b0, done}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a;
        int t;
        int bad;
        int mx;
        int n0;
        int zeros;
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        en       = 1'b0;

        // Reset state
        do_reset(20, 20, 20, 20, 4'hF, -1, -1);
        chk("rst_rdy", rdy, 1);
        chk("rst_done", done, 0);
        chk("rst_key_valid", key_valid, 0);
        chk("rst_key", key, 0);
        chk("rst_chunks", chunks_done, 0);
        chk("rst_core_en", core_en, 0);
        chk("rst_core_abort", core_abort, 0);
        chk("rst_core_base", core_base, 0);

        // Full search without a hit, equal latencies
        start(a);
        chk("t1_rdy_drop", rdy, 0);
        wait_done("t1_done", 2000, t);
        for (int k = 0; k < 4; k++) begin
            chk("t1_first_core", disp_core[k], k);
            chk("t1_first_base", disp_base[k], k * 16);
            chk("t1_first_cyc", disp_cyc[k], a + 1 + k);
        end
        chk("t1_n_disp", n_disp, 16);
        bad = 0;
        for (int c = 0; c < NCHUNK; c++) if (base_cnt[c] != 1) bad++;
        chk("t1_unique_bases", bad, 0);
        chk("t1_chunks", chunks_done, 16);
        chk("t1_key_valid", key_valid, 0);
        mx = 0;
        for (int i = 0; i < NC; i++) if (last_done[i] > mx) mx = last_done[i];
        chk("t1_done_latency", t - mx, 1);
        chk("t1_rdy", rdy, 1);

        // Hit on 0x5A while cores 2 and 3 are still busy
        do_reset(20, 20, 20, 20, 4'hF, 'h5A, -1);
        start(a);
        wait_done("t2_done", 2000, t);
        chk("t2_key", key, 'h5A);
        chk("t2_key_valid", key_valid, 1);
        chk("t2_abort_mask", abort_seen, 4'b1100);
        chk("t2_abort_cycles", abort_cycles, 1);
        chk("t2_core_rdy_at_done", core_rdy, 4'hF);
        chk("t2_chunks", chunks_done, 5);

        // Cores 1 and 3 hit in the same cycle: lowest index wins
        do_reset(30, 22, 30, 20, 4'hF, 'h1F, 'h3F);
        start(a);
        wait_done("t3_done", 2000, t);
        chk("t3_key", key, 'h1F);
        chk("t3_key_valid", key_valid, 1);
        chk("t3_abort_mask", abort_seen, 4'b0101);
        chk("t3_chunks", chunks_done, 0);

        // Hit in the last chunk with no other core busy: done 3 cycles after hit
        do_reset(20, 20, 20, 20, 4'hF, 'hF5, -1);
        start(a);
        wait_done("t4_done", 2000, t);
        chk("t4_key", key, 'hF5);
        chk("t4_abort_mask", abort_seen, 4'b0000);
        chk("t4_hit_latency", t - last_done[3], 3);
        chk("t4_chunks", chunks_done, 15);

        // Unequal latencies on two cores
        do_reset(5, 40, 0, 0, 4'b0011, -1, -1);
        start(a);
        wait_done("t5_done", 2000, t);
        chk("t5_core0_chunks", per_core[0], 13);
        chk("t5_core1_chunks", per_core[1], 3);
        chk("t5_done_after_core1", t - last_done[1], 1);
        chk("t5_chunks", chunks_done, 16);

        // Asynchronous reset in the middle of a run
        do_reset(30, 30, 30, 30, 4'b0011, -1, -1);
        start(a);
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        chk("t6_arst_rdy", rdy, 1);
        chk("t6_arst_done", done, 0);
        chk("t6_arst_chunks", chunks_done, 0);
        chk("t6_arst_core_en", core_en, 0);
        chk("t6_arst_core_base", core_base, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        start(a);
        tick();
        chk("t6_restart_core", disp_core[0], 0);
        chk("t6_restart_base", disp_base[0], 0);
        chk("t6_restart_cyc", disp_cyc[0], a + 1);
        wait_done("t6_done", 2000, t);
        chk("t6_chunks", chunks_done, 16);

        // en in DONE restarts; en held high during RUN is ignored
        n0 = n_disp;
        en = 1'b1;
        tick();
        chk("t7_done_falls", done, 0);
        chk("t7_chunks_cleared", chunks_done, 0);
        chk("t7_rdy_low", rdy, 0);
        repeat (10) tick();
        chk("t7_rdy_still_low", rdy, 0);
        en = 1'b0;
        wait_done("t7_done", 2000, t);
        zeros = 0;
        for (int k = n0; k < n_disp; k++) if (disp_base[k] == 0) zeros++;
        chk("t7_base0_once", zeros, 1);
        chk("t7_n_disp", n_disp - n0, 16);
        chk("t7_chunks", chunks_done, 16);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
